// File: rtl/mem_arb_pkg.sv
// Shared definitions for the cache memory-port arbiter.
// Holds the FSM state encoding, the master index constants and the default watchdog limit.
// Imported by the arbiter top and its watchdog.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int DEFAULT_TIMEOUT = 64;

  // Grant state that corresponds to a master index.
  function automatic arb_state_e owner_state(input logic owner);
    return (owner == M1) ? GNT1 : GNT0;
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Watchdog for a granted bus cycle: counts cycles spent waiting for the slave ack.
// 'expired' is combinational on the count and is high once the count reaches TIMEOUT-1.
// The counter saturates at the limit; 'clear' or rst returns it to zero.
module arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  // Count waiting cycles; hold at the limit so expiry stays visible until cleared.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (run && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign expired = (r_cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the single Wishbone-style memory port (refill vs. MSHR writeback).
// Grant appears one cycle after request; slave-side signals are a combinational mux on the owner.
// A non-owner request waits until the owner completes, aborts, or is timed out by the watchdog.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_cyc_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic          m1_cyc_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          cyc_o,
  output logic          we_o,
  output logic [AW-1:0] adr_o,
  output logic [DW-1:0] dat_o,
  input  logic [DW-1:0] dat_i,
  input  logic          ack_i
);

  arb_state_e r_state;
  logic       r_last_grant;

  logic w_gnt;
  logic w_gnt0;
  logic w_gnt1;
  logic w_owner;
  logic w_own_cyc;
  logic w_expired;
  logic w_timeout;
  logic w_done;
  logic w_pick;

  assign w_gnt0    = (r_state == GNT0);
  assign w_gnt1    = (r_state == GNT1);
  assign w_gnt     = w_gnt0 | w_gnt1;
  assign w_owner   = w_gnt1 ? M1 : M0;
  assign w_own_cyc = w_owner ? m1_cyc_i : m0_cyc_i;

  // Expiry only matters while the owner still holds cyc; a same-cycle ack takes precedence.
  assign w_timeout = w_gnt & w_own_cyc & w_expired & ~ack_i;

  // The bus cycle ends on ack, owner abort, or watchdog expiry.
  assign w_done = w_gnt & (ack_i | ~w_own_cyc | w_timeout);

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (r_state == IDLE),
    .run     (w_gnt & ~ack_i),
    .expired (w_expired)
  );

  // Choose the next owner from the current requests: alternate on ties unless master 0 has priority.
  always_comb begin
    w_pick = M0;
    if (m0_cyc_i && m1_cyc_i) begin
      w_pick = (FIXED_PRIO != 0) ? M0 : ~r_last_grant;
    end else if (m1_cyc_i) begin
      w_pick = M1;
    end
  end

  // Grant FSM: IDLE arbitrates, GNTx holds the lock until the cycle ends, then one IDLE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= M1;
    end else begin
      case (r_state)
        IDLE: begin
          if (m0_cyc_i || m1_cyc_i) begin
            r_state <= owner_state(w_pick);
          end
        end
        GNT0, GNT1: begin
          if (w_done) begin
            r_state      <= IDLE;
            r_last_grant <= w_owner;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Slave side follows the owner directly; forced low on the expiry cycle.
  assign cyc_o = w_gnt & w_own_cyc & ~w_timeout;
  assign we_o  = w_gnt & (w_owner ? m1_we_i : m0_we_i);
  assign adr_o = w_gnt ? (w_owner ? m1_adr_i : m0_adr_i) : '0;
  assign dat_o = w_gnt ? (w_owner ? m1_dat_i : m0_dat_i) : '0;

  // Return path: only the owner sees ack/err, and nothing is reported for a cycle killed by reset.
  assign m0_ack_o = w_gnt0 & ack_i & m0_cyc_i & ~rst;
  assign m1_ack_o = w_gnt1 & ack_i & m1_cyc_i & ~rst;
  assign m0_err_o = w_gnt0 & w_timeout & ~rst;
  assign m1_err_o = w_gnt1 & w_timeout & ~rst;
  assign m0_dat_o = w_gnt0 ? dat_i : '0;
  assign m1_dat_o = w_gnt1 ? dat_i : '0;

endmodule
